sram_uart_mem_ctrl: RTL and testbench
=====================================

// Module: sram_uart_mem_ctrl
// PURPOSE
//   Parametrised data-memory controller between the pipeline MEM stage and board SRAM + UART.
//   Successor to the fixed two-phase controller: configurable widths, SRAM wait states,
//   UART strobe width, and a valid/ready/response handshake so the pipeline stalls on busy.
//   Optional blocking UART mode stalls instead of requiring software polling.
//   Memory-mapped UART data/status addresses are decoded in-block.
// PARAMETERS
//   DATA_W       16       data width (CPU and SRAM)
//   CPU_ADDR_W   16       CPU address width
//   SRAM_ADDR_W  18       SRAM address width; CPU address zero-extended
//   WAIT_STATES  1        extra cycles OE_n/WE_n held low beyond the first (0..7)
//   UART_PULSE   2        cycles rdn/wrn held low (1..7)
//   UART_DATA_A  16'hBF00 UART data register address
//   UART_STAT_A  16'hBF01 UART status register address
//   BLOCKING     0        1: data read waits for data_ready, write waits for tbre&tsre
// PORTS
//   CLK        in   1            clock, all logic on rising edge
//   RST        in   1            asynchronous, active-low reset
//   req_valid  in   1            CPU request; held until accepted
//   req_we     in   1            1 write, 0 read
//   req_addr   in   CPU_ADDR_W   request address
//   req_wdata  in   DATA_W       write data
//   req_ready  out  1            high only in IDLE; accept = req_valid & req_ready
//   rsp_valid  out  1            one-cycle completion pulse (reads and writes)
//   rsp_rdata  out  DATA_W       read data, valid with rsp_valid, held until next read
//   ram_en_n / ram_oe_n / ram_we_n  out 1 each   SRAM strobes, active low
//   ram_addr   out  SRAM_ADDR_W  SRAM address
//   ram_data   inout DATA_W      SRAM data bus
//   tbre, tsre, data_ready  in 1 each   UART status inputs
//   rdn, wrn   out  1            UART read/write strobes, active low
// BEHAVIOUR
//   Reset: state IDLE; all *_n, rdn, wrn = 1; ram_addr = 0; rsp_valid = 0; rsp_rdata = 0;
//     ram_data = Z. Reset mid-transaction aborts it: strobes go inactive immediately, no rsp.
//   Accept cycle T0 latches we/addr/wdata; decode uses latched address only.
//   FSM: IDLE, SETUP, ACCESS, HOLD, STAT, U_WAIT, U_STROBE, U_REC.
//   SRAM (addr not UART_*_A): SETUP (T1) en_n=0, ram_addr driven, oe_n=we_n=1;
//     ACCESS WAIT_STATES+1 cycles with oe_n=0 (read) or we_n=0 (write), en_n=0;
//     read data captured into rsp_rdata at end of last ACCESS cycle;
//     HOLD 1 cycle: oe_n=we_n=1, en_n=0, rsp_valid=1 -> IDLE. Latency T0 to rsp = WAIT_STATES+3.
//   ram_data driven with latched wdata in SETUP/ACCESS/HOLD of writes only, else Z.
//   en_n = 1 in IDLE and all UART states.
//   UART_STAT_A read -> STAT: rsp_rdata = {0.., data_ready, tbre&tsre} sampled in STAT,
//     rsp_valid=1 in STAT -> IDLE. Write to UART_STAT_A: no side effect, acked via STAT.
//   UART_DATA_A: BLOCKING=1 -> U_WAIT until data_ready (read) / tbre&tsre (write);
//     BLOCKING=0 -> U_WAIT skipped. U_STROBE: rdn or wrn low UART_PULSE cycles;
//     write drives ram_data=wdata; read captures ram_data at end of last low cycle;
//     U_REC 1 cycle, strobes high, rsp_valid=1 -> IDLE.
//   rdn and wrn never low together; oe_n and we_n never low together.
//   req_valid while req_ready=0 ignored; next accept earliest cycle after rsp_valid.
//   Strobe counter 3 bits, loaded with count-1, counts down to 0; no wrap.
// STRUCTURE
//   Package mem_ctrl_pkg: state enum, decode enum {DEC_SRAM, DEC_UDATA, DEC_USTAT},
//     default address constants.
//   Sub-module mem_strobe_timer: loadable 3-bit down-counter with done flag, shared by
//     ACCESS and U_STROBE.
// TESTING
//   Reset: RST low during ACCESS of a write -> en_n/oe_n/we_n=1 same cycle, ram_data Z,
//     no rsp_valid; after release req_ready=1.
//   SRAM, WAIT_STATES=1: write 0x1234 @0x0042 -> ram_addr 0x00042, we_n low 2 cycles,
//     rsp_valid T0+4; read @0x0042 -> oe_n low 2 cycles, rsp_rdata 0x1234 at T0+4.
//   Status: data_ready=1, tbre=1, tsre=0, read 0xBF01 -> rsp_rdata 0x0002 at T0+1, en_n=1.
//   BLOCKING=1 write 0x0041 @0xBF00, tsre=0 for 5 cycles -> wrn high throughout, then low
//     exactly 2 cycles after tsre=1, rsp_valid one cycle later.
//   BLOCKING=0 read 0xBF00, data_ready=0, bus 0x00AB -> rdn low 2 cycles, rsp_rdata 0x00AB.
//   Back-to-back: req_valid held 10 cycles -> req_ready low outside IDLE, exactly one
//     rsp_valid per accept, oe_n/we_n never both low.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the SRAM/UART data-memory controller.
// Holds the FSM state encoding, the address decode classes and the default UART addresses.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_HOLD,
        S_STAT,
        S_U_WAIT,
        S_U_STROBE,
        S_U_REC
    } state_e;

    typedef enum logic [1:0] {
        DEC_SRAM,
        DEC_UDATA,
        DEC_USTAT
    } dec_e;

    localparam int          STROBE_CNT_W    = 3;
    localparam logic [15:0] DEF_UART_DATA_A = 16'hBF00;
    localparam logic [15:0] DEF_UART_STAT_A = 16'hBF01;

endpackage

// File: rtl/mem_strobe_timer.sv
// Loadable down-counter timing SRAM access and UART strobe widths.
// Loaded with (cycles - 1); done is high while the count sits at zero, and it never wraps.
module mem_strobe_timer
    import mem_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [STROBE_CNT_W-1:0] load_val,
    input  logic                    dec,
    output logic                    done
);

    logic [STROBE_CNT_W-1:0] cnt_q;
    logic [STROBE_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - STROBE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/sram_uart_mem_ctrl.sv
// Data-memory controller between the pipeline MEM stage and board SRAM plus a memory-mapped UART.
// Valid/ready request, one-cycle response pulse; SRAM strobes stretched by wait states.
module sram_uart_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int                    DATA_W      = 16,
    parameter int                    CPU_ADDR_W  = 16,
    parameter int                    SRAM_ADDR_W = 18,
    parameter int                    WAIT_STATES = 1,
    parameter int                    UART_PULSE  = 2,
    parameter logic [CPU_ADDR_W-1:0] UART_DATA_A = CPU_ADDR_W'(DEF_UART_DATA_A),
    parameter logic [CPU_ADDR_W-1:0] UART_STAT_A = CPU_ADDR_W'(DEF_UART_STAT_A),
    parameter bit                    BLOCKING    = 1'b0
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   req_valid,
    input  logic                   req_we,
    input  logic [CPU_ADDR_W-1:0]  req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   req_ready,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   ram_en_n,
    output logic                   ram_oe_n,
    output logic                   ram_we_n,
    output logic [SRAM_ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0]      ram_data,
    input  logic                   tbre,
    input  logic                   tsre,
    input  logic                   data_ready,
    output logic                   rdn,
    output logic                   wrn
);

    localparam logic [STROBE_CNT_W-1:0] ACCESS_CNT = STROBE_CNT_W'(WAIT_STATES);
    localparam logic [STROBE_CNT_W-1:0] PULSE_CNT  = STROBE_CNT_W'(UART_PULSE - 1);

    state_e                  state_q, state_d;
    logic                    we_q, we_d;
    logic [CPU_ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;

    dec_e                    req_dec;
    logic [DATA_W-1:0]       status_word;
    logic                    uart_ok;
    logic                    tmr_load;
    logic [STROBE_CNT_W-1:0] tmr_val;
    logic                    tmr_dec;
    logic                    tmr_done;
    logic                    bus_drive;

    mem_strobe_timer u_timer (
        .clk      (CLK),
        .rst_n    (RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .done     (tmr_done)
    );

    // Classify the incoming address at accept; the chosen path is then carried by the state.
    always_comb begin
        req_dec = DEC_SRAM;
        if (req_addr == UART_DATA_A) begin
            req_dec = DEC_UDATA;
        end else if (req_addr == UART_STAT_A) begin
            req_dec = DEC_USTAT;
        end
    end

    always_comb begin
        status_word    = '0;
        status_word[1] = data_ready;
        status_word[0] = tbre & tsre;
    end

    assign uart_ok = we_q ? (tbre & tsre) : data_ready;

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        tmr_dec     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    case (req_dec)
                        DEC_SRAM:  state_d = S_SETUP;
                        DEC_USTAT: state_d = S_STAT;
                        DEC_UDATA: begin
                            if (BLOCKING) begin
                                state_d = S_U_WAIT;
                            end else begin
                                state_d  = S_U_STROBE;
                                tmr_load = 1'b1;
                                tmr_val  = PULSE_CNT;
                            end
                        end
                        default:   state_d = S_IDLE;
                    endcase
                end
            end
            S_SETUP: begin
                state_d  = S_ACCESS;
                tmr_load = 1'b1;
                tmr_val  = ACCESS_CNT;
            end
            S_ACCESS: begin
                if (tmr_done) begin
                    state_d = S_HOLD;
                    if (!we_q) begin
                        rsp_rdata_d = ram_data;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_HOLD: begin
                state_d = S_IDLE;
            end
            S_STAT: begin
                state_d = S_IDLE;
                if (!we_q) begin
                    rsp_rdata_d = status_word;
                end
            end
            S_U_WAIT: begin
                if (uart_ok) begin
                    state_d  = S_U_STROBE;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_CNT;
                end
            end
            S_U_STROBE: begin
                if (tmr_done) begin
                    state_d = S_U_REC;
                    if (!we_q) begin
                        rsp_rdata_d = ram_data;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_U_REC: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Strobes decode straight from state so an asynchronous reset releases them at once.
    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_HOLD) || (state_q == S_STAT) || (state_q == S_U_REC);
    assign ram_en_n  = !((state_q == S_SETUP) || (state_q == S_ACCESS) || (state_q == S_HOLD));
    assign ram_oe_n  = !((state_q == S_ACCESS) && !we_q);
    assign ram_we_n  = !((state_q == S_ACCESS) && we_q);
    assign rdn       = !((state_q == S_U_STROBE) && !we_q);
    assign wrn       = !((state_q == S_U_STROBE) && we_q);
    assign ram_addr  = SRAM_ADDR_W'(addr_q);

    // Status reads present the live flags in the response cycle itself.
    assign rsp_rdata = ((state_q == S_STAT) && !we_q) ? status_word : rsp_rdata_q;

    assign bus_drive = we_q && ((state_q == S_SETUP) || (state_q == S_ACCESS) ||
                                (state_q == S_HOLD)  || (state_q == S_U_STROBE));

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bus
        assign ram_data[gi] = bus_drive ? wdata_q[gi] : 1'bz;
    end

endmodule

// File: tb/tb_sram_uart_mem_ctrl.sv
// Directed bench: vector table of single transactions plus reset, blocking-UART and back-to-back sequences.
module tb_sram_uart_mem_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_valid_b = 1'b0;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        tbre = 1'b0, tsre = 1'b0, data_ready = 1'b0;
    logic [15:0] uart_bus = '0;

    logic        req_ready, rsp_valid, ram_en_n, ram_oe_n, ram_we_n, rdn, wrn;
    logic [15:0] rsp_rdata;
    logic [17:0] ram_addr;
    wire  [15:0] ram_data;

    logic        req_ready_b, rsp_valid_b, ram_en_n_b, ram_oe_n_b, ram_we_n_b, rdn_b, wrn_b;
    logic [15:0] rsp_rdata_b;
    logic [17:0] ram_addr_b;
    wire  [15:0] ram_data_b;

    logic [15:0] mem [0:255];
    int          n_chk = 0;
    int          n_fail = 0;
    int          overlap_cnt = 0;

    always #5 CLK = ~CLK;

    sram_uart_mem_ctrl #(.BLOCKING(1'b0)) u_dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_en_n(ram_en_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram_addr(ram_addr),
        .ram_data(ram_data), .tbre(tbre), .tsre(tsre), .data_ready(data_ready), .rdn(rdn), .wrn(wrn)
    );

    sram_uart_mem_ctrl #(.BLOCKING(1'b1)) u_dut_b (
        .CLK(CLK), .RST(RST), .req_valid(req_valid_b), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready_b), .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
        .ram_en_n(ram_en_n_b), .ram_oe_n(ram_oe_n_b), .ram_we_n(ram_we_n_b), .ram_addr(ram_addr_b),
        .ram_data(ram_data_b), .tbre(tbre), .tsre(tsre), .data_ready(data_ready), .rdn(rdn_b), .wrn(wrn_b)
    );

    // SRAM and UART receive-register models driving the shared bus
    assign ram_data = (!ram_en_n && !ram_oe_n) ? mem[ram_addr[7:0]] : (!rdn ? uart_bus : 16'hzzzz);

    always @(posedge CLK) begin
        if (!ram_en_n && !ram_we_n) mem[ram_addr[7:0]] <= ram_data;
    end

    always @(negedge CLK) begin
        if ((!ram_oe_n && !ram_we_n) || (!rdn && !wrn) ||
            (!ram_oe_n_b && !ram_we_n_b) || (!rdn_b && !wrn_b)) overlap_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        dr, tb, ts;
        logic [15:0] bus;
        logic        chk_rdata;
        logic [15:0] exp_rdata;
        int          lat, n_en, n_oe, n_we, n_rd, n_wr;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                                input logic dr, input logic tb, input logic ts, input logic [15:0] bus,
                                input logic chk_rd, input logic [15:0] exp_rd, input int lat,
                                input int n_en, input int n_oe, input int n_we, input int n_rd, input int n_wr);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.dr = dr; v.tb = tb; v.ts = ts; v.bus = bus;
        v.chk_rdata = chk_rd; v.exp_rdata = exp_rd; v.lat = lat;
        v.n_en = n_en; v.n_oe = n_oe; v.n_we = n_we; v.n_rd = n_rd; v.n_wr = n_wr;
        return v;
    endfunction

    vec_t vecs[12];

    initial begin
        int lat, c_en, c_oe, c_we, c_rd, c_wr, bus_bad, addr_bad, waitc;
        int early, nlow, first_low, rsp_k, accepts, rsps, ready_busy, rsp_in_rst;
        logic busy;
        logic [15:0] zz;
        zz = 16'hzzzz;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        //        we    addr      wdata     dr    tb    ts    bus       chk   exp_rd    lat en oe we rd wr
        vecs[0]  = mk(1'b1, 16'h0042, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 4, 4, 0, 2, 0, 0);
        vecs[1]  = mk(1'b0, 16'h0042, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 4, 4, 2, 0, 0, 0);
        vecs[2]  = mk(1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 4, 4, 0, 2, 0, 0);
        vecs[3]  = mk(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 4, 4, 2, 0, 0, 0);
        vecs[4]  = mk(1'b0, 16'hBF01, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1'b0, 16'hBF01, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0001, 1, 0, 0, 0, 0, 0);
        vecs[6]  = mk(1'b0, 16'hBF01, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0003, 1, 0, 0, 0, 0, 0);
        vecs[7]  = mk(1'b0, 16'hBF00, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h00AB, 1'b1, 16'h00AB, 3, 0, 0, 0, 2, 0);
        vecs[8]  = mk(1'b1, 16'hBF00, 16'h0041, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h00AB, 3, 0, 0, 0, 0, 2);
        vecs[9]  = mk(1'b1, 16'hBF01, 16'hFFFF, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h00AB, 1, 0, 0, 0, 0, 0);
        vecs[10] = mk(1'b1, 16'hBF02, 16'h5A5A, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 4, 4, 0, 2, 0, 0);
        vecs[11] = mk(1'b0, 16'hBF02, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h5A5A, 4, 4, 2, 0, 0, 0);

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_strobes", {26'd0, ram_en_n, ram_oe_n, ram_we_n, rdn, wrn, req_ready}, 32'h3F);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("rst_ram_addr", {14'd0, ram_addr}, 32'd0);
        chk("rst_ram_data_z", {16'd0, ram_data}, {16'd0, zz});
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_release_ready", {31'd0, req_ready}, 32'd1);

        // Vector table: one transaction per entry
        foreach (vecs[i]) begin
            req_we = vecs[i].we; req_addr = vecs[i].addr; req_wdata = vecs[i].wdata;
            data_ready = vecs[i].dr; tbre = vecs[i].tb; tsre = vecs[i].ts; uart_bus = vecs[i].bus;
            req_valid = 1'b1;
            @(posedge CLK);
            #1 req_valid = 1'b0;
            lat = -1; c_en = 0; c_oe = 0; c_we = 0; c_rd = 0; c_wr = 0; bus_bad = 0; addr_bad = 0;
            for (int k = 1; k <= 20; k++) begin
                @(negedge CLK);
                if (!ram_en_n) c_en++;
                if (!ram_oe_n) c_oe++;
                if (!ram_we_n) c_we++;
                if (!rdn) c_rd++;
                if (!wrn) c_wr++;
                if ((!ram_we_n || !wrn) && (ram_data !== vecs[i].wdata)) bus_bad++;
                if (!ram_en_n && (ram_addr !== {2'b00, vecs[i].addr})) addr_bad++;
                if (rsp_valid) begin
                    lat = k;
                    break;
                end
            end
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_strobes", i), {c_en[3:0], c_oe[3:0], c_we[3:0], c_rd[3:0], c_wr[3:0]},
                {vecs[i].n_en[3:0], vecs[i].n_oe[3:0], vecs[i].n_we[3:0], vecs[i].n_rd[3:0], vecs[i].n_wr[3:0]});
            if (vecs[i].chk_rdata) chk($sformatf("v%0d_rdata", i), {16'd0, rsp_rdata}, {16'd0, vecs[i].exp_rdata});
            if (vecs[i].we) chk($sformatf("v%0d_wbus", i), bus_bad, 0);
            if (vecs[i].n_en > 0) chk($sformatf("v%0d_ram_addr", i), addr_bad, 0);
            @(negedge CLK);
            chk($sformatf("v%0d_single_rsp", i), {31'd0, rsp_valid}, 32'd0);
        end

        // Reset during ACCESS of a write
        req_we = 1'b1; req_addr = 16'h0020; req_wdata = 16'h7777; req_valid = 1'b1;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        waitc = 0;
        while (ram_we_n && waitc < 10) begin
            @(negedge CLK);
            waitc++;
        end
        chk("mid_rst_reached_access", {31'd0, ram_we_n}, 32'd0);
        RST = 1'b0;
        #1;
        chk("mid_rst_strobes", {29'd0, ram_en_n, ram_oe_n, ram_we_n}, 32'h7);
        chk("mid_rst_bus_z", {16'd0, ram_data}, {16'd0, zz});
        chk("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        rsp_in_rst = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            if (rsp_valid || !req_ready) rsp_in_rst++;
        end
        chk("mid_rst_idle_after", rsp_in_rst, 0);

        // Blocking UART write held off by tsre
        req_we = 1'b1; req_addr = 16'hBF00; req_wdata = 16'h0041;
        tbre = 1'b1; tsre = 1'b0; data_ready = 1'b0;
        req_valid_b = 1'b1;
        @(posedge CLK);
        #1 req_valid_b = 1'b0;
        early = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            if (!wrn_b || rsp_valid_b) early++;
        end
        chk("blk_wrn_held_high", early, 0);
        tsre = 1'b1;
        nlow = 0; first_low = -1; rsp_k = -1; bus_bad = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            if (!wrn_b) begin
                nlow++;
                if (first_low < 0) first_low = k;
                if (ram_data_b !== 16'h0041) bus_bad++;
            end
            if (!rdn_b || !ram_en_n_b) bus_bad++;
            if (rsp_valid_b) begin
                rsp_k = k;
                break;
            end
        end
        chk("blk_wrn_first_low", first_low, 1);
        chk("blk_wrn_width", nlow, 2);
        chk("blk_rsp_cycle", rsp_k, 3);
        chk("blk_bus_and_others", bus_bad, 0);

        // Back-to-back: req_valid held 10 cycles on an SRAM read
        @(negedge CLK);
        req_we = 1'b0; req_addr = 16'h0042; req_valid = 1'b1;
        accepts = 0; rsps = 0; ready_busy = 0; busy = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k == 10) req_valid = 1'b0;
            if (busy && req_ready) ready_busy++;
            if (rsp_valid) begin
                rsps++;
                busy = 1'b0;
            end
            if (req_valid && req_ready) begin
                accepts++;
                busy = 1'b1;
            end
            @(negedge CLK);
        end
        chk("b2b_accepts", accepts, 2);
        chk("b2b_rsps", rsps, 2);
        chk("b2b_ready_low_busy", ready_busy, 0);
        chk("strobe_overlap", overlap_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
